// File: rtl/tri_raster_sched_if.sv
// Job-source and raster-engine signal bundle for tri_raster_sched.
// Signal suffixes are from the scheduler's point of view (slave modport).
interface tri_sched_if #(
    parameter int PIX_CNT_W = 7
);
    logic                 req0_i;
    logic                 req1_i;
    logic [17:0]          tri0_i;
    logic [17:0]          tri1_i;
    logic                 ack0_o;
    logic                 ack1_o;
    logic                 eng_nt_o;
    logic [2:0]           eng_xi_o;
    logic [2:0]           eng_yi_o;
    logic                 eng_busy_i;
    logic                 eng_po_i;
    logic [2:0]           eng_xo_i;
    logic [2:0]           eng_yo_i;
    logic                 pix_valid_o;
    logic [2:0]           pix_x_o;
    logic [2:0]           pix_y_o;
    logic                 pix_owner_o;
    logic                 done_o;
    logic                 done_owner_o;
    logic [PIX_CNT_W-1:0] done_count_o;
    logic                 sched_busy_o;
    logic                 err_o;

    modport slave (
        input  req0_i, req1_i, tri0_i, tri1_i,
        input  eng_busy_i, eng_po_i, eng_xo_i, eng_yo_i,
        output ack0_o, ack1_o, eng_nt_o, eng_xi_o, eng_yi_o,
        output pix_valid_o, pix_x_o, pix_y_o, pix_owner_o,
        output done_o, done_owner_o, done_count_o, sched_busy_o, err_o
    );

    modport master (
        output req0_i, req1_i, tri0_i, tri1_i,
        output eng_busy_i, eng_po_i, eng_xo_i, eng_yo_i,
        input  ack0_o, ack1_o, eng_nt_o, eng_xi_o, eng_yi_o,
        input  pix_valid_o, pix_x_o, pix_y_o, pix_owner_o,
        input  done_o, done_owner_o, done_count_o, sched_busy_o, err_o
    );
endinterface

// File: rtl/tri_raster_sched.sv
// Two-requester round-robin job scheduler in front of the shared triangle raster engine.
// Optional watchdog abort enabled by defining TRI_SCHED_WATCHDOG_EN.
module tri_raster_sched #(
    parameter int PIX_CNT_W = 7,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    tri_sched_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, SEND1, SEND2, SEND3, WAIT_START, RUN, DONE
    } state_e;

    localparam logic [PIX_CNT_W-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [17:0]          job_q, job_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [PIX_CNT_W-1:0] cnt_q, cnt_d;
    logic                 pix_valid_q, pix_valid_d;
    logic [2:0]           pix_x_q, pix_x_d;
    logic [2:0]           pix_y_q, pix_y_d;

    logic any_req;
    logic grant_idx;
    logic capture;
    logic wd_hit;

    assign any_req   = bus.req0_i | bus.req1_i;
    // On a tie the requester that was not granted last time wins.
    assign grant_idx = (bus.req0_i & bus.req1_i) ? ~last_q : bus.req1_i;
    assign capture   = (state_q == WAIT_START) || (state_q == RUN);

`ifdef TRI_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end

    always_comb begin
        wd_d = wd_q;
        if (state_q == SEND3) wd_d = '0;
        else if (capture)     wd_d = wd_q + WD_W'(1);
    end

    assign wd_hit = capture && (wd_q == WD_W'(TIMEOUT));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign wd_hit         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            job_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q     <= state_d;
            job_q       <= job_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d     = state_q;
        job_d       = job_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        pix_valid_d = capture & bus.eng_po_i;
        pix_x_d     = capture & bus.eng_po_i ? bus.eng_xo_i : 3'd0;
        pix_y_d     = capture & bus.eng_po_i ? bus.eng_yo_i : 3'd0;

        if (capture && bus.eng_po_i && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + PIX_CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = SEND1;
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    job_d   = grant_idx ? bus.tri1_i : bus.tri0_i;
                end
            end
            SEND1: begin
                state_d = SEND2;
                cnt_d   = '0;
            end
            SEND2:      state_d = SEND3;
            SEND3:      state_d = WAIT_START;
            WAIT_START: begin
                if (wd_hit)              state_d = IDLE;
                else if (bus.eng_busy_i) state_d = RUN;
            end
            RUN: begin
                if (wd_hit)               state_d = IDLE;
                else if (!bus.eng_busy_i) state_d = DONE;
            end
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.ack0_o       = (state_q == IDLE) && any_req && !grant_idx;
        bus.ack1_o       = (state_q == IDLE) && any_req && grant_idx;
        bus.eng_nt_o     = (state_q == SEND1);
        bus.eng_xi_o     = 3'd0;
        bus.eng_yi_o     = 3'd0;
        case (state_q)
            SEND1: begin bus.eng_xi_o = job_q[17:15]; bus.eng_yi_o = job_q[14:12]; end
            SEND2: begin bus.eng_xi_o = job_q[11:9];  bus.eng_yi_o = job_q[8:6];   end
            SEND3: begin bus.eng_xi_o = job_q[5:3];   bus.eng_yi_o = job_q[2:0];   end
            default: ;
        endcase
        bus.pix_valid_o  = pix_valid_q;
        bus.pix_x_o      = pix_x_q;
        bus.pix_y_o      = pix_y_q;
        bus.pix_owner_o  = owner_q;
        bus.done_o       = (state_q == DONE) || wd_hit;
        bus.done_owner_o = bus.done_o ? owner_q : 1'b0;
        bus.done_count_o = bus.done_o ? cnt_q : '0;
        bus.sched_busy_o = (state_q != IDLE);
        bus.err_o        = wd_hit;
    end

endmodule

// File: tb/tb_tri_raster_sched.sv
// Directed bench for tri_raster_sched: arbitration, vertex replay, pixel forwarding,
// saturation, watchdog (with or without TRI_SCHED_WATCHDOG_EN) and async reset.
module tb_tri_raster_sched;

    localparam int PIX_CNT_W = 7;
    localparam int TIMEOUT   = 10;

    localparam logic [17:0] TRI_A = {3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2};
    localparam logic [17:0] TRI_B = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd1};

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tri_sched_if #(.PIX_CNT_W(PIX_CNT_W)) bus_if ();

    tri_raster_sched #(.PIX_CNT_W(PIX_CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {bus_if.ack1_o, bus_if.ack0_o, bus_if.eng_nt_o, bus_if.eng_xi_o,
                    bus_if.eng_yi_o, bus_if.pix_valid_o, bus_if.pix_x_o, bus_if.pix_y_o,
                    bus_if.pix_owner_o, bus_if.done_o, bus_if.done_owner_o,
                    bus_if.done_count_o, bus_if.sched_busy_o, bus_if.err_o}, 32'd0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of WAIT_START.
    task automatic start_job(input logic [1:0] req_hold, input logic [1:0] req_after,
                             input bit exp_own, input logic [17:0] exp_tri, input bit noise);
        bus_if.req0_i   = req_hold[0];
        bus_if.req1_i   = req_hold[1];
        bus_if.eng_po_i = noise;
        bus_if.eng_xo_i = 3'd5;
        bus_if.eng_yo_i = 3'd5;
        #1;
        check("ack", {bus_if.ack1_o, bus_if.ack0_o}, exp_own ? 2'b10 : 2'b01);
        tick();
        bus_if.req0_i = req_after[0];
        bus_if.req1_i = req_after[1];
        #1;
        check("ack_clear", {bus_if.ack1_o, bus_if.ack0_o}, 2'b00);
        check("vtx1", {bus_if.eng_nt_o, bus_if.eng_xi_o, bus_if.eng_yi_o},
              {1'b1, exp_tri[17:15], exp_tri[14:12]});
        check("pix_send1", bus_if.pix_valid_o, 1'b0);
        tick();
        check("vtx2", {bus_if.eng_nt_o, bus_if.eng_xi_o, bus_if.eng_yi_o},
              {1'b0, exp_tri[11:9], exp_tri[8:6]});
        check("pix_send2", bus_if.pix_valid_o, 1'b0);
        tick();
        check("vtx3", {bus_if.eng_nt_o, bus_if.eng_xi_o, bus_if.eng_yi_o},
              {1'b0, exp_tri[5:3], exp_tri[2:0]});
        check("pix_send3", bus_if.pix_valid_o, 1'b0);
        tick();
        bus_if.eng_po_i = 1'b0;
        check("vtx_off", {bus_if.eng_nt_o, bus_if.eng_xi_o, bus_if.eng_yi_o}, 7'd0);
        check("pix_wait", {bus_if.pix_valid_o, bus_if.sched_busy_o}, 2'b01);
    endtask

    // Called at the WAIT_START negedge; returns at the negedge of the IDLE after DONE.
    task automatic run_engine(input bit exp_own, input int npix, input int exp_cnt);
        bus_if.eng_busy_i = 1'b1;
        tick();
        check("run_busy", bus_if.sched_busy_o, 1'b1);
        if (npix == 0) begin
            bus_if.eng_busy_i = 1'b0;
            tick();
        end
        for (int i = 0; i < npix; i++) begin
            bus_if.eng_po_i = 1'b1;
            bus_if.eng_xo_i = 3'(i % 8);
            bus_if.eng_yo_i = 3'((i / 8) % 8);
            if (i == npix - 1) bus_if.eng_busy_i = 1'b0;
            tick();
            check("pix", {bus_if.pix_valid_o, bus_if.pix_owner_o, bus_if.pix_x_o, bus_if.pix_y_o},
                  {1'b1, exp_own, 3'(i % 8), 3'((i / 8) % 8)});
        end
        bus_if.eng_po_i = 1'b0;
        check("done", {bus_if.done_o, bus_if.done_owner_o, bus_if.err_o}, {1'b1, exp_own, 1'b0});
        check("done_count", bus_if.done_count_o, exp_cnt);
        check("ack_in_done", {bus_if.ack1_o, bus_if.ack0_o}, 2'b00);
        tick();
        check("back_idle", {bus_if.done_o, bus_if.sched_busy_o, bus_if.pix_valid_o}, 3'b000);
    endtask

    initial begin
        reset             = 1'b1;
        bus_if.req0_i     = 1'b0;
        bus_if.req1_i     = 1'b0;
        bus_if.tri0_i     = TRI_A;
        bus_if.tri1_i     = TRI_B;
        bus_if.eng_busy_i = 1'b0;
        bus_if.eng_po_i   = 1'b0;
        bus_if.eng_xo_i   = 3'd0;
        bus_if.eng_yo_i   = 3'd0;
        #1;
        check_all_zero("reset_outputs");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("post_reset_idle");

        // Tie from reset goes to requester 0, then strict alternation while both are held.
        start_job(2'b11, 2'b11, 1'b0, TRI_A, 1'b0);
        run_engine(1'b0, 5, 5);
        start_job(2'b11, 2'b11, 1'b1, TRI_B, 1'b0);
        run_engine(1'b1, 4, 4);
        start_job(2'b11, 2'b11, 1'b0, TRI_A, 1'b1);
        run_engine(1'b0, 3, 3);
        start_job(2'b11, 2'b00, 1'b1, TRI_B, 1'b0);
        run_engine(1'b1, 130, 127);

        // Engine never drops busy: two pixels, then either a watchdog abort or an endless wait.
        start_job(2'b10, 2'b00, 1'b1, TRI_B, 1'b0);
        bus_if.eng_busy_i = 1'b1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            bus_if.eng_po_i = (k <= 2);
            bus_if.eng_xo_i = 3'(k);
            bus_if.eng_yo_i = 3'(k);
            tick();
            if (k < TIMEOUT) check("wd_early", {bus_if.err_o, bus_if.done_o}, 2'b00);
        end
        bus_if.eng_po_i = 1'b0;
`ifdef TRI_SCHED_WATCHDOG_EN
        check("wd_abort", {bus_if.err_o, bus_if.done_o, bus_if.done_owner_o, bus_if.sched_busy_o},
              4'b1111);
        check("wd_count", bus_if.done_count_o, 2);
        tick();
        check("wd_idle", {bus_if.err_o, bus_if.done_o, bus_if.sched_busy_o}, 3'b000);
        start_job(2'b10, 2'b00, 1'b1, TRI_B, 1'b0);
        bus_if.eng_busy_i = 1'b1;
        tick();
`else
        check("no_wd", {bus_if.err_o, bus_if.done_o, bus_if.sched_busy_o}, 3'b001);
        repeat (20) tick();
        check("no_wd_late", {bus_if.err_o, bus_if.done_o, bus_if.sched_busy_o}, 3'b001);
`endif

        // Asynchronous reset in RUN, then a normal grant with the pointer back at its reset value.
        check("owner_pre_rst", {bus_if.pix_owner_o, bus_if.sched_busy_o}, 2'b11);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        reset             = 1'b0;
        bus_if.eng_busy_i = 1'b0;
        tick();
        check_all_zero("after_reset");
        start_job(2'b11, 2'b00, 1'b0, TRI_A, 1'b0);
        run_engine(1'b0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
